// File: rtl/lc_int_pkg.sv
// rtl/lc_int_pkg.sv - shared defaults and FSM state type for the interrupt collector
package lc_int_pkg;

    localparam int LC_INT_DEPTH_DEF   = 13;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int CNT_W_DEF          = $clog2(TIMEOUT_CYCLES_DEF);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_REPRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/lc_int_collector_if.sv
// rtl/lc_int_collector_if.sv - interrupt source, clear and status bundle for the collector
interface lc_int_collector_if
    import lc_int_pkg::*;
#(
    parameter int DEPTH = LC_INT_DEPTH_DEF
);

    logic [DEPTH-1:0] int_src;
    logic [DEPTH-1:0] int_mask;
    logic [DEPTH-1:0] clr_int_external;
    logic             lost_clr;
    logic [DEPTH-1:0] int_vector;
    logic [DEPTH-1:0] int_lost;
    logic             int_timeout;
    logic             busy;

    modport master (
        output int_src, int_mask, clr_int_external, lost_clr,
        input  int_vector, int_lost, int_timeout, busy
    );

    modport slave (
        input  int_src, int_mask, clr_int_external, lost_clr,
        output int_vector, int_lost, int_timeout, busy
    );

endinterface

// File: rtl/int_src_sync.sv
// rtl/int_src_sync.sv - one-bit synchronizer chain with rising-edge event detector
module int_src_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic src_i,
    output logic event_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   delayed_q;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], src_i};
    assign event_o = sync_q[SYNC_STAGES-1] & ~delayed_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/lc_int_collector.sv
// rtl/lc_int_collector.sv - pending/lost tracking with timed re-presentation of unserviced interrupts
module lc_int_collector
    import lc_int_pkg::*;
#(
    parameter int LC_INT_DEPTH   = LC_INT_DEPTH_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    lc_int_collector_if.slave  bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [LC_INT_DEPTH-1:0] src_event;
    logic [LC_INT_DEPTH-1:0] accepted;
    logic [LC_INT_DEPTH-1:0] pending_q, pending_d;
    logic [LC_INT_DEPTH-1:0] lost_q, lost_d;
    logic [LC_INT_DEPTH-1:0] int_vector_q, int_vector_d;
    logic                    int_timeout_q, int_timeout_d;
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    for (genvar i = 0; i < LC_INT_DEPTH; i++) begin : g_src
        int_src_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .src_i   (bus.int_src[i]),
            .event_o (src_event[i])
        );
    end

    // A new event beats a same-cycle clear, both for pending and for the lost flag.
    always_comb begin
        accepted  = src_event & bus.int_mask;
        pending_d = (pending_q & ~bus.clr_int_external) | accepted;
        lost_d    = bus.lost_clr ? '0 : lost_q;
        lost_d    = lost_d | (accepted & pending_q & ~bus.clr_int_external);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pending_q == '0) begin
                    state_d = ST_IDLE;
                end else if (bus.clr_int_external != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_REPRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REPRESENT: begin
                state_d = (pending_q != '0) ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so the dropout lines up with REPRESENT.
        int_timeout_d = (state_d == ST_REPRESENT);
        int_vector_d  = int_timeout_d ? '0 : pending_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q     <= '0;
            lost_q        <= '0;
            int_vector_q  <= '0;
            int_timeout_q <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
        end else begin
            pending_q     <= pending_d;
            lost_q        <= lost_d;
            int_vector_q  <= int_vector_d;
            int_timeout_q <= int_timeout_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.int_vector  = int_vector_q;
    assign bus.int_lost    = lost_q;
    assign bus.int_timeout = int_timeout_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lc_int_collector.sv
// tb/tb_lc_int_collector.sv - scoreboard bench for lc_int_collector with directed and random traffic
module tb_lc_int_collector;
    import lc_int_pkg::*;

    localparam int D = LC_INT_DEPTH_DEF;
    localparam int S = 2;
    localparam int T = 8;

    typedef struct packed {
        logic [D-1:0] vec;
        logic [D-1:0] lost;
        logic         to;
        logic         busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc_int_collector_if #(.DEPTH(D)) bus ();

    lc_int_collector #(
        .LC_INT_DEPTH   (D),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: source history, pending/lost sets, and a re-presentation deadline.
    exp_t         expq[$];
    logic [D-1:0] hist[$];
    logic [D-1:0] m_pend = '0;
    logic [D-1:0] m_lost = '0;
    int           m_mode = 0;   // 0 quiet, 1 waiting for service, 2 re-presenting
    longint       cyc = 0;
    longint       deadline = 0;

    initial begin
        logic [D-1:0] ev;
        logic [D-1:0] acc;
        logic [D-1:0] pend_old;
        exp_t         e;
        for (int k = 0; k < S + 2; k++) hist.push_back('0);
        forever begin
            @(posedge clk);
            cyc++;
            hist.push_front(rst ? '0 : bus.int_src);
            if (rst) begin
                m_pend = '0;
                m_lost = '0;
                m_mode = 0;
                e      = '0;
            end else begin
                ev       = hist[S] & ~hist[S+1];
                acc      = ev & bus.int_mask;
                pend_old = m_pend;
                m_lost   = (bus.lost_clr ? '0 : m_lost) | (acc & pend_old & ~bus.clr_int_external);
                m_pend   = (pend_old & ~bus.clr_int_external) | acc;
                if (m_mode == 1) begin
                    if (pend_old == '0) m_mode = 0;
                    else if (bus.clr_int_external != '0) deadline = cyc + T;
                    else if (cyc == deadline) m_mode = 2;
                end else if (pend_old != '0) begin
                    m_mode   = 1;
                    deadline = cyc + T;
                end else begin
                    m_mode = 0;
                end
                e.vec  = (m_mode == 2) ? '0 : pend_old;
                e.lost = m_lost;
                e.to   = (m_mode == 2);
                e.busy = (m_mode != 0);
            end
            void'(hist.pop_back());
            expq.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("sb_vec",  32'(bus.int_vector),  32'(e.vec));
                chk("sb_lost", 32'(bus.int_lost),    32'(e.lost));
                chk("sb_to",   32'(bus.int_timeout), 32'(e.to));
                chk("sb_busy", 32'(bus.busy),        32'(e.busy));
            end
        end
    end

    initial begin
        int b;
        rst = 1'b1;
        bus.int_src          = '0;
        bus.int_mask         = '1;
        bus.clr_int_external = '0;
        bus.lost_clr         = 1'b0;
        step(4);
        chk("rst_vec",  32'(bus.int_vector),  32'h0);
        chk("rst_lost", 32'(bus.int_lost),    32'h0);
        chk("rst_to",   32'(bus.int_timeout), 32'h0);
        chk("rst_busy", 32'(bus.busy),        32'h0);
        rst = 1'b0;
        step(3);

        // single event, latency and clear
        bus.int_src[3] = 1'b1;
        step(3);
        chk("c1_early", 32'(bus.int_vector), 32'h0);
        step(1);
        chk("c1_vec",  32'(bus.int_vector), 32'h0008);
        chk("c1_busy", 32'(bus.busy),       32'h1);
        bus.clr_int_external = 13'h0008;
        step(1);
        bus.clr_int_external = '0;
        step(1);
        chk("c1_clr_vec",  32'(bus.int_vector), 32'h0);
        chk("c1_clr_busy", 32'(bus.busy),       32'h0);

        // masked source
        bus.int_src = '0;
        step(4);
        bus.int_mask   = ~13'h0020;
        bus.int_src[5] = 1'b1;
        step(2);
        bus.int_src[5] = 1'b0;
        step(6);
        chk("c2_vec",  32'(bus.int_vector), 32'h0);
        chk("c2_lost", 32'(bus.int_lost),   32'h0);
        bus.int_mask = '1;

        // lost event and its clear
        bus.int_src[0] = 1'b1;
        step(2);
        bus.int_src[0] = 1'b0;
        step(4);
        bus.int_src[0] = 1'b1;
        step(5);
        chk("c3_lost", 32'(bus.int_lost), 32'h0001);
        bus.lost_clr = 1'b1;
        step(1);
        bus.lost_clr = 1'b0;
        chk("c3_lostclr", 32'(bus.int_lost), 32'h0);
        bus.int_src          = '0;
        bus.clr_int_external = '1;
        step(1);
        bus.clr_int_external = '0;
        step(2);

        // event and clear on the same bit in the same cycle
        bus.int_src[2] = 1'b1;
        step(5);
        bus.int_src[2] = 1'b0;
        step(2);
        bus.int_src[2] = 1'b1;
        step(2);
        bus.clr_int_external = 13'h0004;
        step(1);
        bus.clr_int_external = '0;
        step(1);
        chk("c4_vec2",  32'(bus.int_vector[2]), 32'h1);
        chk("c4_lost2", 32'(bus.int_lost[2]),   32'h0);
        bus.int_src          = '0;
        bus.clr_int_external = '1;
        step(1);
        bus.clr_int_external = '0;
        step(3);

        // re-presentation period
        bus.int_src[7] = 1'b1;
        step(4);
        chk("c5_vec_on",  32'(bus.int_vector), 32'h0080);
        step(7);
        chk("c5_vec_pre", 32'(bus.int_vector),  32'h0080);
        chk("c5_to_pre",  32'(bus.int_timeout), 32'h0);
        step(1);
        chk("c5_vec_rep", 32'(bus.int_vector),  32'h0);
        chk("c5_to_rep",  32'(bus.int_timeout), 32'h1);
        step(1);
        chk("c5_vec_back", 32'(bus.int_vector),  32'h0080);
        chk("c5_to_back",  32'(bus.int_timeout), 32'h0);
        step(8);
        chk("c5_vec_rep2", 32'(bus.int_vector),  32'h0);
        chk("c5_to_rep2",  32'(bus.int_timeout), 32'h1);

        // reset during WAIT with a source held high
        bus.int_src = 13'h0002;
        step(5);
        rst = 1'b1;
        step(1);
        chk("c6_rst_vec",  32'(bus.int_vector),  32'h0);
        chk("c6_rst_lost", 32'(bus.int_lost),    32'h0);
        chk("c6_rst_to",   32'(bus.int_timeout), 32'h0);
        chk("c6_rst_busy", 32'(bus.busy),        32'h0);
        step(3);
        rst = 1'b0;
        step(3);
        chk("c6_early", 32'(bus.int_vector), 32'h0);
        step(1);
        chk("c6_vec", 32'(bus.int_vector), 32'h0002);
        step(12);
        chk("c6_lost", 32'(bus.int_lost), 32'h0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, D - 1);
                bus.int_src[b] = ~bus.int_src[b];
            end
            if ($urandom_range(0, 31) == 0) bus.int_mask = D'($urandom | $urandom);
            bus.clr_int_external = ($urandom_range(0, 11) == 0) ? D'($urandom & $urandom) : '0;
            bus.lost_clr         = ($urandom_range(0, 19) == 0);
            step(1);
        end
        bus.int_src          = '0;
        bus.clr_int_external = '0;
        bus.lost_clr         = 1'b0;
        step(5);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc_int_collector.md
LC_INT_COLLECTOR -- requirements
Module: lc_int_collector

Interface
REQ-001 Parameter LC_INT_DEPTH, default 13, number of interrupt sources and width of all per-source vectors.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop count per source; minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, cycles without a clear before re-presentation; range 2..65536.
REQ-004 CLK  input  1  single clock for every flop in the block.
REQ-005 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 INT_SRC  input  LC_INT_DEPTH  raw interrupt sources, asynchronous to CLK; event = rising edge.
REQ-007 INT_MASK  input  LC_INT_DEPTH  per-source enable, 1 = accept events; synchronous to CLK.
REQ-008 CLR_INT_EXTERNAL  input  LC_INT_DEPTH  per-source clear from the isolated layer controller, synchronous, one cycle per clear.
REQ-009 LOST_CLR  input  1  single-cycle clear of INT_LOST.
REQ-010 INT_VECTOR  output  LC_INT_DEPTH  pending interrupts presented to the layer controller, registered.
REQ-011 INT_LOST  output  LC_INT_DEPTH  sticky flag: an event arrived while its source was already pending.
REQ-012 INT_TIMEOUT  output  1  one-cycle pulse on each re-presentation.
REQ-013 BUSY  output  1  high whenever FSM is not IDLE.

Function
REQ-014 Each INT_SRC bit SHALL pass through SYNC_STAGES flops; a one-flop delayed copy of the last stage SHALL form the edge detector; event[i] = synced & ~delayed.
REQ-015 Latency: INT_SRC[i] sampled high at edge N, with the event accepted, SHALL give INT_VECTOR[i]=1 after edge N+SYNC_STAGES+1 (3 cycles at default).
REQ-016 event[i] with INT_MASK[i]=0 SHALL be discarded; it SHALL NOT set pending or INT_LOST.
REQ-017 Accepted event[i] SHALL set pending[i]; CLR_INT_EXTERNAL[i] SHALL clear it; when both occur in the same cycle, set wins.
REQ-018 Accepted event[i] while pending[i]=1 and CLR_INT_EXTERNAL[i]=0 SHALL set INT_LOST[i]; LOST_CLR clears all bits; set wins over LOST_CLR.
REQ-019 Clearing INT_MASK[i] SHALL NOT clear an already pending bit.
REQ-020 FSM states are IDLE, WAIT, and REPRESENT.
REQ-021 IDLE: goes to WAIT when pending != 0; counter = 0.
REQ-022 WAIT: counter increments each cycle.
REQ-023 WAIT: counter resets to 0 in any cycle with CLR_INT_EXTERNAL != 0.
REQ-024 WAIT: goes to IDLE when pending becomes 0.
REQ-025 WAIT: goes to REPRESENT when counter reaches TIMEOUT_CYCLES-1.
REQ-026 REPRESENT lasts exactly one cycle: INT_VECTOR forced to 0, INT_TIMEOUT=1.
REQ-027 REPRESENT: pending is retained; events and clears are still processed.
REQ-028 REPRESENT: next state is WAIT with counter 0, or IDLE if pending is 0.
REQ-029 INT_VECTOR = pending, except during REPRESENT.
REQ-030 REPRESENT creates a fresh 0->1 edge on INT_VECTOR as a renewed wake request; re-presentation repeats without limit.
REQ-031 Counter width SHALL be clog2(TIMEOUT_CYCLES); it SHALL never wrap past TIMEOUT_CYCLES-1.

Reset
REQ-032 RESET=1 SHALL zero all synchronizer, edge, pending, INT_LOST, and counter flops, and force state IDLE.
REQ-033 All outputs SHALL be 0 in the cycle after reset is sampled.
REQ-034 A source held high through reset release SHALL produce exactly one event after release.
REQ-035 Reset asserted mid-WAIT or mid-REPRESENT SHALL abort the FSM with no INT_TIMEOUT pulse.

Structure
REQ-036 Shared package lc_int_pkg SHALL hold the LC_INT_DEPTH default, the FSM state enum, and the TIMEOUT_CYCLES default and counter width.
REQ-037 One sub-module, int_src_sync (synchronizer plus edge detector, 1 bit), SHALL be instantiated LC_INT_DEPTH times.
REQ-038 Pending, lost, FSM and counter logic SHALL live in lc_int_collector.

Verification
REQ-039 Case 1: INT_SRC[3] 0->1, mask all-ones -> INT_VECTOR=13'h0008 exactly 3 cycles later, BUSY=1; CLR_INT_EXTERNAL[3] pulse -> INT_VECTOR=0 next cycle, FSM IDLE.
REQ-040 Case 2: INT_MASK[5]=0, pulse INT_SRC[5] -> INT_VECTOR and INT_LOST stay 0.
REQ-041 Case 3: two edges on INT_SRC[0] 6 cycles apart, no clear -> INT_LOST=13'h0001; LOST_CLR -> 0.
REQ-042 Case 4: new event and CLR_INT_EXTERNAL on bit 2 in the same cycle -> INT_VECTOR[2] stays 1, INT_LOST[2]=0.
REQ-043 Case 5: TIMEOUT_CYCLES=8, pending bit 7, no clears -> INT_VECTOR drops to 0 for one cycle with INT_TIMEOUT=1, 8 cycles after WAIT entry, then returns to 13'h0080; repeats every 9 cycles.
REQ-044 Case 6: RESET asserted during WAIT with INT_SRC[1] held high -> all outputs 0; after release, INT_VECTOR[1]=1 once, 3 cycles later.
